pipe_mdu_ctrl: RTL
==================

// Module: pipe_mdu_ctrl
// PURPOSE
// Iterative multiply/divide sequencer and HI/LO owner for the 5-stage pipeline.
// Accepts mult/multu/div/divu from the ID stage and runs a WIDTH-iteration shift-add
// or restoring-divide sequence. Returns the results in HI/LO.
// Raises stall to ID while busy whenever ID issues another md op, mfhi/mflo or mthi/mtlo.
// Sits beside the ID stage. Operands are the forwarded ID operands a/b.
// PARAMETERS
// WIDTH  32  operand width; iteration count = WIDTH; HI/LO width = WIDTH
// PORTS
// clk     in   1      clock; all state changes on rising edge
// clrn    in   1      asynchronous active-low reset
// start   in   1      ID inst is an md op (ID must gate with its own nostall)
// mdop    in   2      00 mult, 01 multu, 10 div, 11 divu
// a       in   WIDTH  operand rs (dividend / multiplicand); also mthi/mtlo data
// b       in   WIDTH  operand rt (divisor / multiplier)
// rdhilo  in   1      ID inst is mfhi or mflo
// wrhi    in   1      ID inst is mthi
// wrlo    in   1      ID inst is mtlo
// stall   out  1      ID must hold this cycle
// busy    out  1      sequence in progress
// done    out  1      one-cycle pulse after HI/LO are written by a sequence
// hi      out  WIDTH  HI register
// lo      out  WIDTH  LO register
// BEHAVIOUR
// - Reset (clrn=0, async): state=IDLE, count=0, hi=lo=0, done=0. Applies mid-sequence;
//   any in-flight result is discarded.
// - States: IDLE -> RUN (on start & ~busy) -> FIX (count==WIDTH-1) -> IDLE.
// - IDLE, start=1 (edge E0):
//   - latch mdop and the operand magnitudes. Signed ops take |a| and |b|;
//     |0x80000000| = 0x80000000 as unsigned.
//   - latch sign flags; count=0.
// - RUN (edges E1..E_WIDTH): one iteration per edge; count increments; 2*WIDTH-bit
//   accumulator.
//   - mult: add multiplicand if multiplier LSB=1, then shift right.
//   - div: shift left, trial-subtract the divisor, and set the quotient bit if the result
//     is non-negative.
// - FIX (edge E_WIDTH+1): apply sign correction, write hi/lo, return to IDLE;
//   done=1 for the following cycle.
//   - mult: {hi,lo} = product, negated if sign(a)!=sign(b) for mult.
//   - div: lo = quotient, negated if signs differ; hi = remainder carrying the sign of a (div).
//   - Divide by zero (b==0, div or divu): lo = all-ones, hi = a; no sign fix.
// - Latency: hi/lo valid WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
// - busy = (state != IDLE). busy is combinational from state.
// - stall = busy & (start | rdhilo | wrhi | wrlo). stall is combinational, with no
//   dependence on a/b.
//   - A request during FIX is stalled and is accepted in the next IDLE cycle.
//   - hi/lo are never read mid-sequence.
// - Idle writes: wrhi & ~busy -> hi<=a; wrlo & ~busy -> lo<=a; done stays 0.
// - rdhilo & ~busy: no state change; ID reads hi/lo directly.
// - At most one of start/rdhilo/wrhi/wrlo per cycle. Priority if violated:
//   start > wrhi > wrlo. Priority is covered by an assertion.
// - start while busy: ignored (stalled); no effect on the running sequence.
// - hi/lo hold their value in all other cycles.
// STRUCTURE
// - Shared header pipe_mdu_defs.vh holds:
//   - MDOP_* encodings (MULT/MULTU/DIV/DIVU)
//   - state encodings S_IDLE/S_RUN/S_FIX
//   - funct codes for mfhi/mflo/mthi/mtlo/mult/multu/div/divu, used by the control unit
//     decode.
// - One sub-module, mdu_iter: a combinational single-iteration step.
//   - inputs: acc, operand, is_div
//   - output: next acc
//   - instantiated once inside pipe_mdu_ctrl. The FSM and counter stay in the top module.
// TESTING
// 1. mult a=0xFFFFFFFE (-2), b=3 -> after 33 edges {hi,lo}=0xFFFFFFFF_FFFFFFFA; done one cycle.
// 2. divu a=100, b=7 -> lo=14, hi=2. div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3),
//    hi=0xFFFFFFFF (-1).
// 3. div a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678; no X.
// 4. rdhilo at cycle 5 of a multu 0xFFFFFFFF*0xFFFFFFFF -> stall=1 until IDLE; then hi=0xFFFFFFFE,
//    lo=0x00000001.
// 5. clrn pulsed low at RUN count=10 -> immediately busy=0, hi=lo=0, done=0. A new start after
//    release runs the full 33 cycles.
// 6. mthi 0xCAFEF00D when idle -> hi updated next edge, stall=0. A back-to-back start in the
//    FIX cycle is stalled one cycle, then accepted.

Source files
------------

// File: rtl/pipe_mdu_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// and the funct codes the control unit decodes to drive it.
package pipe_mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MDOP_MULT  = 2'b00,
    MDOP_MULTU = 2'b01,
    MDOP_DIV   = 2'b10,
    MDOP_DIVU  = 2'b11
  } mdop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  // Per-sequence fixup flags captured at the accepting edge.
  typedef struct packed {
    logic is_div;
    logic dz;      // divide by zero
    logic neg_lo;  // negate product / quotient
    logic neg_hi;  // negate remainder (div only)
  } op_ctl_t;

  function automatic logic op_is_div(input mdop_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdop_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/pipe_mdu_ctrl_if.sv
// ID-stage <-> multiply/divide unit request and HI/LO response bundle.
interface pipe_mdu_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       mdop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rdhilo;
  logic             wrhi;
  logic             wrlo;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, mdop, a, b, rdhilo, wrhi, wrlo,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, mdop, a, b, rdhilo, wrhi, wrlo,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/pipe_mdu_ctrl_iter.sv
// One shift-add multiply or restoring-divide iteration on a 2*WIDTH accumulator.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // mult: acc = {partial, multiplier}; carry out of the add shifts back in
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
    // div: acc = {remainder, dividend}; remainder < divisor so the W-bit diff is exact
    shl  = acc[2*WIDTH-1:WIDTH-1];
    ge   = (shl >= {1'b0, operand});
    diff = shl[WIDTH-1:0] - operand;
    if (is_div)
      nxt = {(ge ? diff : shl[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    else
      nxt = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Iterative mult/multu/div/divu sequencer and HI/LO owner beside the ID stage.
module pipe_mdu_ctrl
  import pipe_mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             clrn,
  pipe_mdu_ctrl_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;
  op_ctl_t            ctl;

  mdop_e              op_in;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               busy;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .acc     (acc),
    .operand (opnd),
    .is_div  (ctl.is_div),
    .nxt     (acc_nxt)
  );

  always_comb begin
    op_in = mdop_e'(bus.mdop);
    neg_a = op_is_signed(op_in) & bus.a[WIDTH-1];
    neg_b = op_is_signed(op_in) & bus.b[WIDTH-1];
    // the most negative value maps to itself, which is its correct unsigned magnitude
    mag_a = neg_a ? -bus.a : bus.a;
    mag_b = neg_b ? -bus.b : bus.b;

    prod  = ctl.neg_lo ? -acc : acc;
    rem   = acc[2*WIDTH-1:WIDTH];
    if (ctl.is_div) begin
      // divide by zero leaves rem = |a|, so the sign of a restores hi = a
      fix_lo = ctl.dz ? '1 : (ctl.neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      fix_hi = ctl.neg_hi ? -rem : rem;
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      ctl    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_RUN;
            count      <= '0;
            ctl.is_div <= op_is_div(op_in);
            ctl.dz     <= op_is_div(op_in) & (bus.b == '0);
            ctl.neg_lo <= neg_a ^ neg_b;
            ctl.neg_hi <= op_is_div(op_in) ? neg_a : (neg_a ^ neg_b);
            if (op_is_div(op_in)) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end else if (bus.wrhi) begin
            hi_r <= bus.a;
          end else if (bus.wrlo) begin
            lo_r <= bus.a;
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi_r   <= fix_hi;
          lo_r   <= fix_lo;
          done_r <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.start | bus.rdhilo | bus.wrhi | bus.wrlo);
  assign bus.done  = done_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

  a_start_wins: assert property (@(posedge clk) disable iff (!clrn)
    (!busy && bus.start) |=> (state == S_RUN));
  a_wrhi_over_wrlo: assert property (@(posedge clk) disable iff (!clrn)
    (!busy && !bus.start && bus.wrhi && bus.wrlo) |=> (lo_r == $past(lo_r)));

endmodule
